// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
// Optional source tag output is enabled with FIFO_ARB_TAG_EN.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int BURST_CNT_W = 8;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request after i_last_owner.
// Shared by write- and read-side schedulers.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last_owner,
    output logic [IW-1:0] o_winner,
    output logic          o_any_req
);

    // Walk from farthest to nearest so the nearest match is written last.
    always_comb begin
        int w_idx;
        w_idx     = 0;
        o_winner  = '0;
        o_any_req = 1'b0;
        for (int k = N; k >= 1; k--) begin
            w_idx = (int'(i_last_owner) + k) % N;
            if (i_req[IW'(w_idx)]) begin
                o_winner  = IW'(w_idx);
                o_any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the synchronous FIFO write port.
// Define FIFO_ARB_TAG_EN to add the fifo_tag source-index output.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATAWIDTH = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*DATAWIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]             gnt,
    output logic                         fifo_wr_en,
    output logic [DATAWIDTH-1:0]         fifo_data_in,
    input  logic                         fifo_full,
`ifdef FIFO_ARB_TAG_EN
    output logic [idx_w(N_REQ)-1:0]      fifo_tag,
`endif
    output logic                         busy
);

    localparam int IW = idx_w(N_REQ);
    localparam logic [BURST_CNT_W-1:0] MB = BURST_CNT_W'(MAX_BURST);

    arb_state_t             r_state;
    logic [IW-1:0]          r_owner;
    logic [IW-1:0]          r_last_owner;
    logic [BURST_CNT_W-1:0] r_burst_cnt;

    logic [IW-1:0]          w_winner;
    logic                   w_any_req;
    logic [N_REQ-1:0]       w_gnt;
    logic [DATAWIDTH-1:0]   w_data;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .i_req        (req),
        .i_last_owner (r_last_owner),
        .o_winner     (w_winner),
        .o_any_req    (w_any_req)
    );

    // Reset gates the grant so an in-flight beat is dropped at once.
    always_comb begin
        w_gnt = '0;
        if (!reset && !fifo_full) begin
            if (r_state == IDLE) begin
                if (w_any_req) w_gnt[w_winner] = 1'b1;
            end else begin
                w_gnt[r_owner] = req[r_owner];
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) w_data = req_data[i*DATAWIDTH +: DATAWIDTH];
        end
    end

`ifdef FIFO_ARB_TAG_EN
    always_comb begin
        fifo_tag = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) fifo_tag = IW'(i);
        end
    end
`endif

    assign gnt          = w_gnt;
    assign fifo_wr_en   = |w_gnt;
    assign fifo_data_in = w_data;
    assign busy         = (r_state == BURST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_last_owner <= IW'(N_REQ - 1);
            r_burst_cnt  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any_req && !fifo_full) begin
                        r_owner     <= w_winner;
                        r_burst_cnt <= BURST_CNT_W'(1);
                        if (MAX_BURST == 1) r_last_owner <= w_winner;
                        else                r_state      <= BURST;
                    end
                end
                BURST: begin
                    if (!req[r_owner]) begin
                        r_state      <= IDLE;
                        r_last_owner <= r_owner;
                    end else if (!fifo_full) begin
                        r_burst_cnt <= r_burst_cnt + BURST_CNT_W'(1);
                        if (r_burst_cnt + BURST_CNT_W'(1) == MB) begin
                            r_state      <= IDLE;
                            r_last_owner <= r_owner;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: MAX_BURST=4 and MAX_BURST=1 instances
// checked against a transaction-level round-robin model.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic        fifo_full = 1'b0;

    logic [3:0]  gnt_a, gnt_b;
    logic        we_a, we_b, busy_a, busy_b;
    logic [7:0]  d_a, d_b;
`ifdef FIFO_ARB_TAG_EN
    logic [1:0]  tag_a, tag_b;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N_REQ(4), .DATAWIDTH(8), .MAX_BURST(4)) u_a (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .gnt(gnt_a), .fifo_wr_en(we_a), .fifo_data_in(d_a),
        .fifo_full(fifo_full),
`ifdef FIFO_ARB_TAG_EN
        .fifo_tag(tag_a),
`endif
        .busy(busy_a));

    fifo_wr_arbiter #(.N_REQ(4), .DATAWIDTH(8), .MAX_BURST(1)) u_b (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .gnt(gnt_b), .fifo_wr_en(we_b), .fifo_data_in(d_b),
        .fifo_full(fifo_full),
`ifdef FIFO_ARB_TAG_EN
        .fifo_tag(tag_b),
`endif
        .busy(busy_b));

    logic [3:0] obs_g [2];
    logic [7:0] obs_d [2];
    logic       obs_w [2];
    logic       obs_b [2];
    assign obs_g[0] = gnt_a;  assign obs_g[1] = gnt_b;
    assign obs_d[0] = d_a;    assign obs_d[1] = d_b;
    assign obs_w[0] = we_a;   assign obs_w[1] = we_b;
    assign obs_b[0] = busy_a; assign obs_b[1] = busy_b;

    int tests = 0;
    int fails = 0;

    // Model: owner (-1 = nobody), beats used, last owner.
    int maxb  [2] = '{4, 1};
    int m_own [2];
    int m_used[2];
    int m_last[2];
    int         exp_w [2];
    logic [3:0] exp_g [2];
    logic [7:0] exp_d [2];
    logic       exp_b [2];

    function automatic int rr(logic [3:0] r, int last);
        for (int k = 1; k <= 4; k++)
            if (r[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    task automatic mreset();
        for (int m = 0; m < 2; m++) begin
            m_own[m] = -1; m_used[m] = 0; m_last[m] = 3;
        end
    endtask

    task automatic settle();
        #2;
        for (int m = 0; m < 2; m++) begin
            int w;
            if (m_own[m] < 0) w = rr(req, m_last[m]);
            else w = req[m_own[m]] ? m_own[m] : -1;
            if (fifo_full || reset) w = -1;
            exp_w[m] = w;
            exp_g[m] = (w < 0) ? 4'd0 : 4'(1 << w);
            exp_d[m] = 8'd0;
            if (w >= 0) exp_d[m] = req_data[w*8 +: 8];
            exp_b[m] = (m_own[m] >= 0) && !reset;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                m_own[m] = -1; m_used[m] = 0; m_last[m] = 3;
            end else if (m_own[m] < 0) begin
                if (exp_w[m] >= 0) begin
                    m_used[m] = 1;
                    if (maxb[m] == 1) m_last[m] = exp_w[m];
                    else m_own[m] = exp_w[m];
                end
            end else if (!req[m_own[m]]) begin
                m_last[m] = m_own[m]; m_own[m] = -1;
            end else if (exp_w[m] >= 0) begin
                m_used[m]++;
                if (m_used[m] == maxb[m]) begin
                    m_last[m] = m_own[m]; m_own[m] = -1;
                end
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; req = '0; fifo_full = 1'b0;
        @(posedge clk);
        mreset();
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 4'b0101; req_data = $urandom;
        #2;
        for (int m = 0; m < 2; m++) begin
            tests++;
            if (obs_g[m] !== 4'd0 || obs_w[m] !== 1'b0 ||
                obs_b[m] !== 1'b0 || obs_d[m] !== 8'd0) begin
                fails++;
                $display("FAIL reset_out[%0d] gnt=%b we=%b busy=%b d=%h want all 0",
                         m, obs_g[m], obs_w[m], obs_b[m], obs_d[m]);
            end
        end
        @(posedge clk); mreset(); #1;
        reset = 1'b0; req = 4'b1111;
        settle();
        tests++;
        if (gnt_a !== 4'b0001) begin
            fails++; $display("FAIL reset_first gnt=%b want 0001", gnt_a);
        end
        advance();
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        apply_reset();
        req = 4'b0101;
        for (int c = 0; c < 12; c++) begin
            req_data = $urandom;
            want = ((c / 4) % 2 == 0) ? 4'b0001 : 4'b0100;
            settle();
            tests++;
            if (gnt_a !== want || d_a !== exp_d[0] || we_a !== 1'b1) begin
                fails++;
                $display("FAIL rr_beat%0d gnt=%b d=%h we=%b want %b %h 1",
                         c, gnt_a, d_a, we_a, want, exp_d[0]);
            end
            advance();
        end
    endtask

    task automatic test_drop();
        logic [3:0] want [4] = '{4'b0001, 4'b0001, 4'b0000, 4'b1000};
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            req = (c < 2) ? 4'b0001 : 4'b1000;
            settle();
            tests++;
            if (gnt_a !== want[c]) begin
                fails++; $display("FAIL drop_c%0d gnt=%b want %b", c, gnt_a, want[c]);
            end
            advance();
        end
    endtask

    task automatic test_stall();
        logic [3:0] want [8] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000,
                                 4'b0000, 4'b0001, 4'b0001, 4'b0010};
        apply_reset();
        req = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            fifo_full = (c >= 2 && c <= 4);
            req_data = $urandom;
            settle();
            tests++;
            if (gnt_a !== want[c] || we_a !== (want[c] != 0) ||
                busy_a !== (c >= 1 && c <= 6)) begin
                fails++;
                $display("FAIL stall_c%0d gnt=%b we=%b busy=%b want gnt %b",
                         c, gnt_a, we_a, busy_a, want[c]);
            end
            advance();
        end
        fifo_full = 1'b0;
    endtask

    task automatic test_burst1();
        logic [3:0] want [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        apply_reset();
        req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            settle();
            tests++;
            if (gnt_b !== want[c] || busy_b !== 1'b0) begin
                fails++;
                $display("FAIL mb1_c%0d gnt=%b busy=%b want %b 0", c, gnt_b, busy_b, want[c]);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req = 4'b0001;
        settle(); advance();
        settle(); advance();
        #2;
        tests++;
        if (gnt_a !== 4'b0001 || busy_a !== 1'b1) begin
            fails++; $display("FAIL mid_pre gnt=%b busy=%b want 0001 1", gnt_a, busy_a);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (gnt_a !== 4'd0 || we_a !== 1'b0 || busy_a !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset gnt=%b we=%b busy=%b want 0 0 0", gnt_a, we_a, busy_a);
        end
        @(posedge clk); mreset(); #1;
        reset = 1'b0; req = 4'b1111;
        settle();
        tests++;
        if (gnt_a !== 4'b0001) begin
            fails++; $display("FAIL mid_after gnt=%b want 0001", gnt_a);
        end
        advance();
    endtask

`ifdef FIFO_ARB_TAG_EN
    task automatic test_tag();
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            req = 4'b1000;
            fifo_full = (c == 3);
            settle();
            tests++;
            if (tag_a !== (we_a ? 2'd3 : 2'd0) || we_a !== (c != 3)) begin
                fails++; $display("FAIL tag_c%0d tag=%0d we=%b", c, tag_a, we_a);
            end
            advance();
        end
        fifo_full = 1'b0;
    endtask
`endif

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            req       = 4'($urandom_range(0, 15));
            req_data  = $urandom;
            fifo_full = ($urandom_range(0, 3) == 0);
            settle();
            for (int m = 0; m < 2; m++) begin
                tests++;
                if (obs_g[m] !== exp_g[m] || obs_d[m] !== exp_d[m] ||
                    obs_b[m] !== exp_b[m] || obs_w[m] !== (exp_w[m] >= 0)) begin
                    fails++;
                    $display("FAIL rand_c%0d_i%0d gnt=%b d=%h busy=%b we=%b want %b %h %b",
                             c, m, obs_g[m], obs_d[m], obs_b[m], obs_w[m],
                             exp_g[m], exp_d[m], exp_b[m]);
                end
                tests++;
                if (obs_w[m] === 1'b1 && fifo_full) begin
                    fails++; $display("FAIL rand_full_c%0d_i%0d we=1 want 0", c, m);
                end
            end
`ifdef FIFO_ARB_TAG_EN
            tests++;
            if (tag_a !== ((exp_w[0] >= 0) ? 2'(exp_w[0]) : 2'd0)) begin
                fails++; $display("FAIL rand_tag_c%0d tag=%0d want %0d", c, tag_a, exp_w[0]);
            end
`endif
            advance();
        end
    endtask

    initial begin
        mreset();
        test_reset();
        test_round_robin();
        test_drop();
        test_stall();
        test_burst1();
        test_reset_mid();
`ifdef FIFO_ARB_TAG_EN
        test_tag();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
